// File: rtl/aes_word_gather.sv
// aes_word_gather
//   Narrow-to-wide gather register for the AES256 datapath. Packs Beats = NOUT/NIN input beats of
//   NIN words each into one NOUT-word block, with valid/ready on both sides. A second holding slot
//   (the assembly buffer in HOLD) lets a complete block wait while the output slot is stalled.
//
// Ports
//   clk          clock, rising edge
//   resetn       asynchronous active-low reset
//   i_clear      synchronous flush of partial/held data and the output slot (highest priority)
//   i_rev_order  beat order for the block, sampled on its first beat (0: ascending, 1: descending)
//   i_in_valid   input beat valid
//   o_in_ready   input beat accepted when i_in_valid & o_in_ready at the clock edge
//   i_in_data    input beat, word j = i_in_data[j*W +: W]
//   o_out_valid  o_out_data holds a complete block
//   i_out_ready  consumer takes the block when o_out_valid & i_out_ready
//   o_out_data   assembled block, word n = o_out_data[n*W +: W]
//   o_beat_cnt   beats held in the current partial block
//   o_busy       partial data, a held block or a valid output present
module aes_word_gather #(
  parameter int unsigned W     = 8,
  parameter int unsigned NIN   = 4,
  parameter int unsigned NOUT  = 16,
  localparam int unsigned Beats = NOUT / NIN,
  localparam int unsigned CntW  = (Beats > 1) ? $clog2(Beats) : 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                i_clear,
  input  logic                i_rev_order,
  input  logic                i_in_valid,
  output logic                o_in_ready,
  input  logic [NIN*W-1:0]    i_in_data,
  output logic                o_out_valid,
  input  logic                i_out_ready,
  output logic [NOUT*W-1:0]   o_out_data,
  output logic [CntW-1:0]     o_beat_cnt,
  output logic                o_busy
);

  if ((NOUT % NIN) != 0 || NOUT < NIN) begin : g_bad_params
    $error("aes_word_gather: NOUT must be a non-zero multiple of NIN");
  end

  localparam logic [CntW-1:0] LastBeat = CntW'(Beats - 1);

  typedef enum logic [0:0] {StFill, StHold} state_e;

  state_e              r_state, w_state_nxt;
  logic [CntW-1:0]     r_beat_cnt, w_beat_cnt_nxt;
  logic                r_rev, w_rev_nxt;
  logic [NOUT*W-1:0]   r_asm, w_asm_nxt;
  logic [NOUT*W-1:0]   r_out_data, w_out_data_nxt;
  logic                r_out_valid, w_out_valid_nxt;

  logic                w_accept;
  logic                w_order;
  logic [CntW-1:0]     w_slot;
  logic [NOUT*W-1:0]   w_asm_beat;

  assign o_in_ready  = (r_state == StFill) && !i_clear;
  assign w_accept    = i_in_valid && o_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_beat_cnt  = r_beat_cnt;
  assign o_busy      = (r_beat_cnt != '0) || (r_state == StHold) || r_out_valid;

  // The first beat of a block uses the live order input; later beats use the sampled copy.
  assign w_order = (r_beat_cnt == '0) ? i_rev_order : r_rev;
  assign w_slot  = w_order ? (LastBeat - r_beat_cnt) : r_beat_cnt;

  // Assembly buffer with the presented beat merged into its slot.
  always_comb begin
    w_asm_beat = r_asm;
    for (int unsigned b = 0; b < Beats; b++) begin
      if (w_slot == CntW'(b)) begin
        w_asm_beat[b*NIN*W +: NIN*W] = i_in_data;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_beat_cnt_nxt  = r_beat_cnt;
    w_rev_nxt       = r_rev;
    w_asm_nxt       = r_asm;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = r_out_valid;

    if (i_clear) begin
      // Data registers are left untouched; only the control state is flushed.
      w_state_nxt     = StFill;
      w_beat_cnt_nxt  = '0;
      w_out_valid_nxt = 1'b0;
    end else begin
      unique case (r_state)
        StFill: begin
          if (r_out_valid && i_out_ready) begin
            w_out_valid_nxt = 1'b0;
          end
          if (w_accept) begin
            w_asm_nxt = w_asm_beat;
            if (r_beat_cnt == '0) begin
              w_rev_nxt = i_rev_order;
            end
            if (r_beat_cnt == LastBeat) begin
              w_beat_cnt_nxt = '0;
              if (!r_out_valid || i_out_ready) begin
                w_out_data_nxt  = w_asm_beat;
                w_out_valid_nxt = 1'b1;
              end else begin
                w_state_nxt = StHold;
              end
            end else begin
              w_beat_cnt_nxt = r_beat_cnt + CntW'(1);
            end
          end
        end
        StHold: begin
          // Output slot is occupied; move the held block in as soon as the current one leaves.
          if (i_out_ready) begin
            w_out_data_nxt  = r_asm;
            w_out_valid_nxt = 1'b1;
            w_state_nxt     = StFill;
          end
        end
        default: w_state_nxt = StFill;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= StFill;
      r_beat_cnt  <= '0;
      r_rev       <= 1'b0;
      r_asm       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_beat_cnt  <= w_beat_cnt_nxt;
      r_rev       <= w_rev_nxt;
      r_asm       <= w_asm_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

endmodule

// File: tb/tb_aes_word_gather.sv
module tb_aes_word_gather;

  localparam int unsigned W     = 8;
  localparam int unsigned NIN   = 4;
  localparam int unsigned NOUT  = 16;
  localparam int unsigned BEATS = NOUT / NIN;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         resetn;
  logic         clear, rev_order, in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0]  in_data;
  logic [127:0] out_data;
  logic [1:0]   beat_cnt;

  // Second instance: W=32, NIN=1, NOUT=8
  logic         b_clear, b_rev, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [31:0]  b_in_data;
  logic [255:0] b_out_data;
  logic [2:0]   b_beat_cnt;

  aes_word_gather #(.W(W), .NIN(NIN), .NOUT(NOUT)) dut (
    .clk(clk), .resetn(resetn), .i_clear(clear), .i_rev_order(rev_order),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
    .o_beat_cnt(beat_cnt), .o_busy(busy)
  );

  aes_word_gather #(.W(32), .NIN(1), .NOUT(8)) dut1 (
    .clk(clk), .resetn(resetn), .i_clear(b_clear), .i_rev_order(b_rev),
    .i_in_valid(b_in_valid), .o_in_ready(b_in_ready), .i_in_data(b_in_data),
    .o_out_valid(b_out_valid), .i_out_ready(b_out_ready), .o_out_data(b_out_data),
    .o_beat_cnt(b_beat_cnt), .o_busy(b_busy)
  );

  // Reference model: a queue of complete blocks (front is what the output shows,
  // a second entry is a block waiting for the output slot) plus the partial block.
  logic [127:0] m_q[$];
  logic [127:0] m_part;
  logic [127:0] m_shown;
  int           m_cnt;
  bit           m_rev;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_part  = '0;
    m_shown = '0;
    m_cnt   = 0;
    m_rev   = 1'b0;
  endtask

  task automatic model_edge();
    bit acc;
    int slot;
    if (!resetn) begin
      model_reset();
      return;
    end
    if (clear) begin
      m_cnt = 0;
      m_q.delete();
      return;
    end
    acc = in_valid && (m_q.size() < 2);
    if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
    if (acc) begin
      if (m_cnt == 0) m_rev = rev_order;
      slot = m_rev ? (BEATS - 1 - m_cnt) : m_cnt;
      for (int j = 0; j < NIN; j++) m_part[(slot*NIN + j)*W +: W] = in_data[j*W +: W];
      m_cnt++;
      if (m_cnt == BEATS) begin
        m_q.push_back(m_part);
        m_cnt = 0;
      end
    end
    if (m_q.size() > 0) m_shown = m_q[0];
  endtask

  task automatic check_regs();
    chk("out_valid", out_valid, m_q.size() > 0);
    chk("out_data", out_data, m_shown);
    chk("beat_cnt", beat_cnt, m_cnt);
    chk("busy", busy, (m_cnt != 0) || (m_q.size() > 0));
  endtask

  // Inputs are set just after a rising edge; check in_ready, clock, then check state.
  task automatic cycle();
    #1 chk("in_ready", in_ready, !clear && (m_q.size() < 2));
    @(posedge clk);
    model_edge();
    #1 check_regs();
  endtask

  task automatic beat(input logic [31:0] d, input logic rev);
    in_valid  = 1'b1;
    in_data   = d;
    rev_order = rev;
    cycle();
  endtask

  logic [31:0]  bw[8];
  logic [255:0] bexp;
  logic [127:0] exp_blk;

  initial begin
    resetn = 1'b0; clear = 1'b0; rev_order = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    b_clear = 1'b0; b_rev = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    model_reset();
    #2 check_regs();
    chk("rst_in_ready", in_ready, 1'b1);
    cycle();
    cycle();
    resetn = 1'b1;

    // W=32, NIN=1, NOUT=8: valid appears after the 8th word
    b_in_valid  = 1'b1;
    b_out_ready = 1'b1;
    bexp = '0;
    for (int i = 0; i < 8; i++) begin
      bw[i] = $urandom;
      bexp[i*32 +: 32] = bw[i];
      b_in_data = bw[i];
      cycle();
      chk("n1_out_valid", b_out_valid, i == 7);
    end
    chk("n1_out_data", b_out_data, bexp);
    b_in_valid = 1'b0;
    cycle();
    chk("n1_consumed", b_out_valid, 1'b0);

    // Defaults, ascending order
    out_ready = 1'b1;
    beat(32'h03020100, 1'b0);
    beat(32'h07060504, 1'b0);
    beat(32'h0B0A0908, 1'b0);
    chk("t1_not_yet", out_valid, 1'b0);
    beat(32'h0F0E0D0C, 1'b0);
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_data", out_data, 128'h0F0E0D0C_0B0A0908_07060504_03020100);

    // Reverse order sampled at beat 0; the toggle at beat 2 is ignored
    beat(32'h03020100, 1'b1);
    beat(32'h07060504, 1'b1);
    beat(32'h0B0A0908, 1'b0);
    beat(32'h0F0E0D0C, 1'b0);
    exp_blk = out_data;
    chk("t2_word0", exp_blk[7:0], 8'h0C);
    chk("t2_word15", exp_blk[127:120], 8'h03);
    chk("t2_data", out_data, 128'h03020100_07060504_0B0A0908_0F0E0D0C);
    in_valid = 1'b0;
    cycle();

    // Output stalled: block 1 shown, block 2 held, then drained with no gap
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) beat(32'h03020100 + 32'h04040404 * (i % 4) + ((i / 4) * 32'h10101010), 1'b0);
    in_valid = 1'b0;
    chk("t3_blk1", out_data, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
    #1 chk("t3_in_ready_low", in_ready, 1'b0);
    out_ready = 1'b1;
    cycle();
    chk("t3_blk2", out_data, 128'h1F1E1D1C_1B1A1918_17161514_13121110);
    chk("t3_blk2_valid", out_valid, 1'b1);
    cycle();
    chk("t3_drained", out_valid, 1'b0);
    chk("t3_in_ready_back", in_ready, 1'b1);

    // Clear after two beats, then a fresh block
    beat(32'hAAAAAAAA, 1'b0);
    beat(32'hBBBBBBBB, 1'b0);
    chk("t4_cnt2", beat_cnt, 2'd2);
    clear = 1'b1;
    beat(32'hCCCCCCCC, 1'b0);
    clear = 1'b0;
    chk("t4_cnt0", beat_cnt, 2'd0);
    beat(32'h44332211, 1'b0);
    beat(32'h88776655, 1'b0);
    beat(32'hCCBBAA99, 1'b0);
    beat(32'h00FFEEDD, 1'b0);
    chk("t4_data", out_data, 128'h00FFEEDD_CCBBAA99_88776655_44332211);
    in_valid = 1'b0;
    cycle();

    // Reset during HOLD takes effect immediately
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) beat($urandom, 1'($urandom));
    in_valid = 1'b0;
    #1 chk("t5_in_hold", in_ready, 1'b0);
    resetn = 1'b0;
    model_reset();
    #1 check_regs();
    chk("t5_in_ready", in_ready, 1'b1);
    chk("t5_out_data", out_data, 128'h0);
    cycle();
    resetn = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      rev_order = 1'($urandom);
      clear     = ($urandom % 25) == 0;
      in_data   = $urandom;
      cycle();
    end
    clear = 1'b0;
    in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
